serial_subtractor: RTL

Bit-serial N-bit subtractor computing A - B one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the inverse-direction companion to the team's ripple full-adder datapath. It serves area-constrained ALU paths where a WIDTH-cycle latency is acceptable. Operands are captured on a start handshake; the result is presented with a one-cycle done pulse and held until the next start.

---
 rtl/serial_subtractor.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// through a single full-subtractor cell and a registered borrow.
// Results (diff, borrow_out, ovf) update only when the operation completes
// and are held until the next completed operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic            brw;
  logic [CW-1:0]   cnt;

  // Full-subtractor cell on the current LSBs.
  logic d_bit, b_next, last_bit;
  assign d_bit    = sa[0] ^ sb[0] ^ brw;
  assign b_next   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
  assign last_bit = (cnt == LAST);

  // State register with asynchronous abort on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // Operand capture, serial shifting and result publication on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            brw <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {d_bit, res[WIDTH-1:1]};
          brw <= b_next;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // On the MSB step sa[0]/sb[0] are the captured sign bits.
            diff       <= {d_bit, res[WIDTH-1:1]};
            borrow_out <= b_next;
            ovf        <= (sa[0] != sb[0]) & (d_bit != sa[0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
